// File: rtl/acc_mult_sched_pkg.sv
// Shared state encoding, default sizing and index-width helper for the
// acc_mult_sched multiplier scheduler and its round-robin arbiter.
package acc_mult_sched_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH1  = 8;
    localparam int DEF_WIDTH2  = 8;
    localparam int DEF_LATENCY = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RUN     = ST_RUN,
        CAPTURE = ST_CAPTURE,
        RESP    = ST_RESP
    } state_t;

    // Bits needed to index n items, never less than 1 so single-entry ranges stay legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational scan from the pointer with wrap-around;
// the pointer moves to one past the winner whenever a grant is taken.
module rr_arbiter
    import acc_mult_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   nxt;

    always_comb begin
        logic [IDW:0] pos;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr} + (IDW+1)'(i);
            if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
            if (!any && req[pos[IDW-1:0]]) begin
                any                   = 1'b1;
                grant[pos[IDW-1:0]]   = 1'b1;
                grant_idx             = pos[IDW-1:0];
            end
        end
    end

    always_comb begin
        nxt = {1'b0, grant_idx} + (IDW+1)'(1);
        if (nxt == (IDW+1)'(NREQ)) nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= nxt[IDW-1:0];
        end
    end

endmodule

// File: rtl/acc_mult_sched.sv
// Shares one multi-cycle accumulating multiplier among NREQ requesters:
// arbitrate, run the multiplier for LATENCY enabled cycles, return a tagged result.
module acc_mult_sched
    import acc_mult_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH1  = DEF_WIDTH1,
    parameter int WIDTH2  = DEF_WIDTH2,
    parameter int LATENCY = DEF_LATENCY,
    parameter int IDW     = clog2_min1(NREQ)
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH1-1:0]   req_a,
    input  logic [NREQ*WIDTH2-1:0]   req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH1+WIDTH2-1:0] rsp_sum,
    output logic [IDW-1:0]           rsp_id,
    output logic                     mult_en,
    output logic [WIDTH1-1:0]        mult_a,
    output logic [WIDTH2-1:0]        mult_b,
    output logic                     mult_cin,
    input  logic [WIDTH1+WIDTH2-1:0] mult_sum,
    output logic                     busy,
    output logic [1:0]               fsm_state
);

    localparam int CW = clog2_min1(LATENCY);

    state_t          state;
    logic [CW-1:0]   run_cnt;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_req;
    logic            accept;

    logic [WIDTH1-1:0] a_slice [NREQ];
    logic [WIDTH2-1:0] b_slice [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_slice[i] = req_a[i*WIDTH1 +: WIDTH1];
        assign b_slice[i] = req_b[i*WIDTH2 +: WIDTH2];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // Both channels transfer on a rising clock edge where valid and ready are
    // both high; valid never depends on ready, and rsp holds until it transfers.
    assign accept    = (state == IDLE) && any_req;
    assign req_ready = (state == IDLE && !sys_rst) ? grant : '0;

    assign mult_en   = (state == RUN);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            run_cnt  <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            mult_cin <= 1'b0;
            rsp_sum  <= '0;
            rsp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mult_a   <= a_slice[grant_idx];
                        mult_b   <= b_slice[grant_idx];
                        mult_cin <= req_cin[grant_idx];
                        rsp_id   <= grant_idx;
                        run_cnt  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (run_cnt == CW'(LATENCY - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        run_cnt <= run_cnt + CW'(1);
                    end
                end
                // Enable has just fallen; the multiplier still presents the finished sum.
                CAPTURE: begin
                    rsp_sum <= mult_sum;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mult_sched.sv
// Directed bench for acc_mult_sched driving a bit-serial accumulating
// multiplier model (one partial product per enabled cycle, clears after 2 idle cycles).
module tb_acc_mult_sched;

    localparam int NREQ = 4;
    localparam int W1   = 8;
    localparam int W2   = 8;
    localparam int LAT  = 8;
    localparam int IDW  = 2;
    localparam int SW   = W1 + W2;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W1-1:0]   req_a;
    logic [NREQ*W2-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [SW-1:0]        rsp_sum;
    logic [IDW-1:0]       rsp_id;
    logic                 mult_en;
    logic [W1-1:0]        mult_a;
    logic [W2-1:0]        mult_b;
    logic                 mult_cin;
    logic [SW-1:0]        mult_sum;
    logic                 busy;
    logic [1:0]           fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int ncyc         = 0;

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    acc_mult_sched #(
        .NREQ(NREQ), .WIDTH1(W1), .WIDTH2(W2), .LATENCY(LAT), .IDW(IDW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .mult_en   (mult_en),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_cin  (mult_cin),
        .mult_sum  (mult_sum),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // accumulating multiplier model
    logic [SW-1:0] m_acc  = '0;
    logic [3:0]    m_k    = '0;
    logic          m_en_d = 1'b0;

    always @(posedge sys_clk) begin
        if (mult_en) begin
            m_acc <= ((m_k == 4'd0) ? {15'd0, mult_cin} : m_acc)
                   + ((m_k < 4'd8 && mult_b[m_k[2:0]]) ? ({8'd0, mult_a} << m_k) : 16'd0);
            m_k   <= m_k + 4'd1;
        end else if (!m_en_d) begin
            m_acc <= '0;
            m_k   <= '0;
        end
        m_en_d <= mult_en;
    end
    assign mult_sum = m_acc;

    // driver tasks
    task automatic step();
        @(negedge sys_clk);
        ncyc++;
    endtask

    task automatic set_req(input int i, input logic [W1-1:0] a, input logic [W2-1:0] b, input logic c);
        req_a[i*W1 +: W1] = a;
        req_b[i*W2 +: W2] = b;
        req_cin[i]        = c;
        req_valid[i]      = 1'b1;
        #1;
    endtask

    task automatic next_grant(input int budget, input bit drop, output bit ok, output int gidx, output int acc_at);
        ok = 1'b0; gidx = -1; acc_at = 0;
        for (int t = 0; t < budget; t++) begin
            if ((req_ready & req_valid) != '0) begin
                ok = 1'b1;
                acc_at = ncyc;
                for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) gidx = i;
                break;
            end
            step();
        end
        if (ok) begin
            step();
            if (drop) req_valid[gidx] = 1'b0;
            #1;
        end
    endtask

    task automatic collect_rsp(input int budget, input int acc_at, output bit ok, output int en_cnt,
                               output int lat, output logic [SW-1:0] sum, output logic [IDW-1:0] id);
        ok = 1'b0; en_cnt = 0; lat = 0; sum = '0; id = '0;
        for (int t = 0; t < budget; t++) begin
            if (rsp_valid) begin
                ok = 1'b1; lat = ncyc - acc_at; sum = rsp_sum; id = rsp_id;
                break;
            end
            if (mult_en) en_cnt++;
            step();
        end
    endtask

    // tests
    task automatic test_reset();
        sys_rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
        repeat (3) step();
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        tests_run++;
        if ({mult_en, mult_a, mult_b, mult_cin} !== 18'd0) begin
            tests_failed++; $display("FAIL reset_mult: got en=%0b a=%0d b=%0d cin=%0b expected all 0", mult_en, mult_a, mult_b, mult_cin);
        end
        tests_run++;
        if ({rsp_valid, rsp_sum, rsp_id} !== 19'd0) begin
            tests_failed++; $display("FAIL reset_rsp: got valid=%0b sum=%0d id=%0d expected all 0", rsp_valid, rsp_sum, rsp_id);
        end
        tests_run++;
        if (busy !== 1'b0 || fsm_state !== 2'd0) begin
            tests_failed++; $display("FAIL reset_state: got busy=%0b state=%0d expected busy=0 state=0", busy, fsm_state);
        end
        req_valid = '0;
        sys_rst   = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit ok; int gidx, acc_at, en_cnt, lat; logic [SW-1:0] sum; logic [IDW-1:0] id;
        set_req(0, 8'd25, 8'd10, 1'b0);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        next_grant(10, 1'b1, ok, gidx, acc_at);
        tests_run++;
        if (!ok || gidx !== 0) begin
            tests_failed++; $display("FAIL single_grant: got ok=%0b idx=%0d expected ok=1 idx=0", ok, gidx);
        end
        tests_run++;
        if (req_ready !== 4'b0000 || mult_en !== 1'b1 || mult_a !== 8'd25 || mult_b !== 8'd10) begin
            tests_failed++; $display("FAIL single_run_start: got ready=%b en=%0b a=%0d b=%0d expected 0000 1 25 10", req_ready, mult_en, mult_a, mult_b);
        end
        collect_rsp(30, acc_at, ok, en_cnt, lat, sum, id);
        tests_run++;
        if (!ok || en_cnt !== 8 || lat !== 10) begin
            tests_failed++; $display("FAIL single_timing: got ok=%0b en_cycles=%0d latency=%0d expected 1 8 10", ok, en_cnt, lat);
        end
        tests_run++;
        if (sum !== 16'd250 || id !== 2'd0) begin
            tests_failed++; $display("FAIL single_result: got sum=%0d id=%0d expected 250 0", sum, id);
        end
        step();
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL single_after_hs: got valid=%0b busy=%0b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_wrap();
        bit ok; int gidx, acc_at, en_cnt, lat; logic [SW-1:0] sum; logic [IDW-1:0] id;
        logic [W2-1:0] neg3;
        neg3 = -8'sd3;
        set_req(2, 8'd200, neg3, 1'b0);
        next_grant(10, 1'b1, ok, gidx, acc_at);
        collect_rsp(30, acc_at, ok, en_cnt, lat, sum, id);
        tests_run++;
        if (!ok || gidx !== 2 || sum !== 16'd50600 || id !== 2'd2) begin
            tests_failed++; $display("FAIL wrap_result: got ok=%0b grant=%0d sum=%0d id=%0d expected 1 2 50600 2", ok, gidx, sum, id);
        end
        step();
    endtask

    task automatic test_all_four();
        bit ok; int gidx, acc_at, en_cnt, lat; logic [SW-1:0] sum; logic [IDW-1:0] id;
        int a_tab [4] = '{3, 5, 7, 9};
        int s_tab [4] = '{33, 55, 77, 99};
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) set_req(k, 8'(a_tab[k]), 8'd11, 1'b0);
            for (int k = 0; k < 4; k++) begin
                next_grant(20, 1'b1, ok, gidx, acc_at);
                tests_run++;
                if (!ok || gidx !== k) begin
                    tests_failed++; $display("FAIL all4_order pass %0d slot %0d: got ok=%0b grant=%0d expected 1 %0d", pass, k, ok, gidx, k);
                end
                collect_rsp(30, acc_at, ok, en_cnt, lat, sum, id);
                tests_run++;
                if (!ok || sum !== 16'(s_tab[k]) || id !== 2'(k)) begin
                    tests_failed++; $display("FAIL all4_result pass %0d slot %0d: got ok=%0b sum=%0d id=%0d expected 1 %0d %0d", pass, k, ok, sum, id, s_tab[k], k);
                end
                step();
            end
        end
    endtask

    task automatic test_stall();
        bit ok; int gidx, acc_at, en_cnt, lat; logic [SW-1:0] sum; logic [IDW-1:0] id;
        rsp_ready = 1'b0;
        set_req(0, 8'd6, 8'd7, 1'b0);
        next_grant(10, 1'b1, ok, gidx, acc_at);
        set_req(1, 8'd2, 8'd9, 1'b0);
        collect_rsp(30, acc_at, ok, en_cnt, lat, sum, id);
        tests_run++;
        if (!ok || sum !== 16'd42 || id !== 2'd0) begin
            tests_failed++; $display("FAIL stall_first: got ok=%0b sum=%0d id=%0d expected 1 42 0", ok, sum, id);
        end
        for (int t = 0; t < 20; t++) begin
            step();
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 16'd42 || rsp_id !== 2'd0 || req_ready !== 4'b0000 || mult_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold cycle %0d: got valid=%0b sum=%0d id=%0d ready=%b en=%0b expected 1 42 0 0000 0",
                         t, rsp_valid, rsp_sum, rsp_id, req_ready, mult_en);
            end
        end
        rsp_ready = 1'b1;
        step();
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL stall_release: got valid=%0b ready=%b expected 0 0010", rsp_valid, req_ready);
        end
        next_grant(10, 1'b1, ok, gidx, acc_at);
        collect_rsp(30, acc_at, ok, en_cnt, lat, sum, id);
        tests_run++;
        if (!ok || gidx !== 1 || sum !== 16'd18 || id !== 2'd1) begin
            tests_failed++; $display("FAIL stall_second: got ok=%0b grant=%0d sum=%0d id=%0d expected 1 1 18 1", ok, gidx, sum, id);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        bit ok; int gidx, acc_at, en_cnt, lat; logic [SW-1:0] sum; logic [IDW-1:0] id;
        int stray;
        set_req(0, 8'd77, 8'd3, 1'b0);
        next_grant(10, 1'b1, ok, gidx, acc_at);
        repeat (3) step();
        tests_run++;
        if (mult_en !== 1'b1 || fsm_state !== 2'd1) begin
            tests_failed++; $display("FAIL midrst_in_run: got en=%0b state=%0d expected 1 1", mult_en, fsm_state);
        end
        sys_rst = 1'b1;
        step();
        tests_run++;
        if (mult_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_abort: got en=%0b busy=%0b valid=%0b expected 0 0 0", mult_en, busy, rsp_valid);
        end
        sys_rst = 1'b0;
        stray = 0;
        for (int t = 0; t < 15; t++) begin
            step();
            if (rsp_valid || mult_en) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++; $display("FAIL midrst_no_rsp: got %0d active cycles expected 0", stray);
        end
        set_req(1, 8'd255, 8'd255, 1'b0);
        next_grant(10, 1'b1, ok, gidx, acc_at);
        collect_rsp(30, acc_at, ok, en_cnt, lat, sum, id);
        tests_run++;
        if (!ok || gidx !== 1 || sum !== 16'd65025 || id !== 2'd1) begin
            tests_failed++; $display("FAIL midrst_next: got ok=%0b grant=%0d sum=%0d id=%0d expected 1 1 65025 1", ok, gidx, sum, id);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int acc_t [$];
        int low_run, min_low, nrsp, bad_rsp;
        bit seen_high;
        bit ok;
        low_run = 0; min_low = 1000; nrsp = 0; bad_rsp = 0; seen_high = 1'b0;
        rsp_ready = 1'b1;
        set_req(3, 8'd12, 8'd12, 1'b1);
        for (int t = 0; t < 45; t++) begin
            if (req_ready[3] && req_valid[3]) acc_t.push_back(ncyc);
            if (rsp_valid) begin
                nrsp++;
                if (rsp_sum !== 16'd145 || rsp_id !== 2'd3) bad_rsp++;
            end
            if (mult_en) begin
                if (seen_high && low_run > 0 && low_run < min_low) min_low = low_run;
                seen_high = 1'b1;
                low_run   = 0;
            end else begin
                low_run++;
            end
            step();
        end
        tests_run++;
        if (acc_t.size() < 4) begin
            tests_failed++; $display("FAIL b2b_accepts: got %0d acceptances expected at least 4", acc_t.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                tests_run++;
                if (acc_t[i] - acc_t[i-1] !== 11) begin
                    tests_failed++; $display("FAIL b2b_spacing %0d: got %0d cycles expected 11", i, acc_t[i] - acc_t[i-1]);
                end
            end
        end
        tests_run++;
        if (min_low !== 3) begin
            tests_failed++; $display("FAIL b2b_en_gap: got min low run %0d expected 3", min_low);
        end
        tests_run++;
        if (nrsp !== 4 || bad_rsp !== 0) begin
            tests_failed++; $display("FAIL b2b_responses: got count=%0d wrong=%0d expected 4 0", nrsp, bad_rsp);
        end
        req_valid[3] = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (!busy) begin ok = 1'b1; break; end
            step();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL b2b_drain: got busy=%0b expected 0 within 30 cycles", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_all_four();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
